// File: rtl/otter_dmem_arbiter.sv
// otter_dmem_arbiter: shares OTTER data-memory port 2 between the CPU (A) and a DMA/loader (B).
// Winner's request is held stable through the synchronous-read response cycle; results are registered.
module otter_dmem_arbiter #(
   parameter int unsigned RR_EN = 1
) (
   input  logic        MEM_CLK,
   input  logic        MEM_RST_N,
   input  logic        A_REQ,
   input  logic        B_REQ,
   input  logic        A_WE,
   input  logic        B_WE,
   input  logic [31:0] A_ADDR,
   input  logic [31:0] B_ADDR,
   input  logic [31:0] A_DIN,
   input  logic [31:0] B_DIN,
   input  logic [1:0]  A_SIZE,
   input  logic [1:0]  B_SIZE,
   input  logic        A_SIGN,
   input  logic        B_SIGN,
   output logic        A_GNT,
   output logic        B_GNT,
   output logic        A_DONE,
   output logic        B_DONE,
   output logic [31:0] A_RDATA,
   output logic [31:0] B_RDATA,
   output logic        A_ERR,
   output logic        B_ERR,
   output logic [31:0] MEM_ADDR2,
   output logic [31:0] MEM_DIN2,
   output logic [1:0]  MEM_SIZE,
   output logic        MEM_SIGN,
   output logic        MEM_WRITE2,
   output logic        MEM_READ2,
   input  logic [31:0] MEM_DOUT2,
   input  logic        MEM_ERR,
   output logic        BUSY
);
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;   // 0 = A, 1 = B
   logic        last_q, last_d;     // requester served most recently
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] din_q, din_d;
   logic [1:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic        a_done_q, a_done_d, b_done_q, b_done_d;
   logic        a_err_q, a_err_d, b_err_q, b_err_d;
   logic [31:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
   logic        win_b;

   always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
      if (!MEM_RST_N) begin
         state_q   <= S_IDLE;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         we_q      <= 1'b0;
         addr_q    <= '0;
         din_q     <= '0;
         size_q    <= '0;
         sign_q    <= 1'b0;
         a_done_q  <= 1'b0;
         b_done_q  <= 1'b0;
         a_err_q   <= 1'b0;
         b_err_q   <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         size_q    <= size_d;
         sign_q    <= sign_d;
         a_done_q  <= a_done_d;
         b_done_q  <= b_done_d;
         a_err_q   <= a_err_d;
         b_err_q   <= b_err_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      we_d      = we_q;
      addr_d    = addr_q;
      din_d     = din_q;
      size_d    = size_q;
      sign_d    = sign_q;
      a_done_d  = 1'b0;
      b_done_d  = 1'b0;
      a_err_d   = a_err_q;
      b_err_d   = b_err_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      // B wins when alone, or on a tie under round-robin when A was served last
      win_b = B_REQ & (~A_REQ | ((RR_EN != 0) & ~last_q));

      case (state_q)
         S_IDLE: begin
            if (A_REQ | B_REQ) begin
               owner_d = win_b;
               last_d  = win_b;
               we_d    = win_b ? B_WE   : A_WE;
               addr_d  = win_b ? B_ADDR : A_ADDR;
               din_d   = win_b ? B_DIN  : A_DIN;
               size_d  = win_b ? B_SIZE : A_SIZE;
               sign_d  = win_b ? B_SIGN : A_SIGN;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (owner_q) b_err_d = MEM_ERR;
            else         a_err_d = MEM_ERR;
            if (we_q) begin
               state_d = S_IDLE;
               if (owner_q) b_done_d = 1'b1;
               else         a_done_d = 1'b1;
            end else begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (owner_q) begin
               b_rdata_d = MEM_DOUT2;
               b_done_d  = 1'b1;
            end else begin
               a_rdata_d = MEM_DOUT2;
               a_done_d  = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // enables decode from state so an asynchronous reset kills a pending write at once
   assign MEM_WRITE2 = (state_q == S_ACCESS) & we_q;
   assign MEM_READ2  = (state_q == S_ACCESS) & ~we_q;
   assign MEM_ADDR2  = addr_q;
   assign MEM_DIN2   = din_q;
   assign MEM_SIZE   = size_q;
   assign MEM_SIGN   = sign_q;
   assign A_GNT      = (state_q == S_ACCESS) & ~owner_q;
   assign B_GNT      = (state_q == S_ACCESS) & owner_q;
   assign A_DONE     = a_done_q;
   assign B_DONE     = b_done_q;
   assign A_ERR      = a_err_q;
   assign B_ERR      = b_err_q;
   assign A_RDATA    = a_rdata_q;
   assign B_RDATA    = b_rdata_q;
   assign BUSY       = (state_q != S_IDLE);
endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Bench for otter_dmem_arbiter: directed scenarios plus random two-requester traffic,
// checked against a byte-array memory and transaction-level arbitration rules.
module tb_otter_dmem_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0, a_sign = 1'b0, b_sign = 1'b0;
   logic [31:0] a_addr = '0, b_addr = '0, a_din = '0, b_din = '0;
   logic [1:0]  a_size = '0, b_size = '0;
   logic        a_gnt, b_gnt, a_done, b_done, a_err, b_err, busy;
   logic [31:0] a_rdata, b_rdata;
   logic [31:0] mem_addr, mem_din, mem_dout, mem_sh;
   logic [1:0]  mem_size;
   logic        mem_sign, mem_write, mem_read, mem_err;
   logic        fp_a_gnt, fp_b_gnt, fp_a_done, fp_b_done, fp_a_err, fp_b_err, fp_busy;
   logic        fp_sign, fp_write, fp_read;
   logic [31:0] fp_a_rdata, fp_b_rdata, fp_addr, fp_din;
   logic [1:0]  fp_size;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   always #5 clk = ~clk;

   otter_dmem_arbiter dut (
      .MEM_CLK(clk), .MEM_RST_N(rst_n),
      .A_REQ(a_req), .B_REQ(b_req), .A_WE(a_we), .B_WE(b_we),
      .A_ADDR(a_addr), .B_ADDR(b_addr), .A_DIN(a_din), .B_DIN(b_din),
      .A_SIZE(a_size), .B_SIZE(b_size), .A_SIGN(a_sign), .B_SIGN(b_sign),
      .A_GNT(a_gnt), .B_GNT(b_gnt), .A_DONE(a_done), .B_DONE(b_done),
      .A_RDATA(a_rdata), .B_RDATA(b_rdata), .A_ERR(a_err), .B_ERR(b_err),
      .MEM_ADDR2(mem_addr), .MEM_DIN2(mem_din), .MEM_SIZE(mem_size), .MEM_SIGN(mem_sign),
      .MEM_WRITE2(mem_write), .MEM_READ2(mem_read), .MEM_DOUT2(mem_dout), .MEM_ERR(mem_err),
      .BUSY(busy)
   );

   otter_dmem_arbiter #(.RR_EN(0)) dut_fp (
      .MEM_CLK(clk), .MEM_RST_N(rst_n),
      .A_REQ(a_req), .B_REQ(b_req), .A_WE(a_we), .B_WE(b_we),
      .A_ADDR(a_addr), .B_ADDR(b_addr), .A_DIN(a_din), .B_DIN(b_din),
      .A_SIZE(a_size), .B_SIZE(b_size), .A_SIGN(a_sign), .B_SIGN(b_sign),
      .A_GNT(fp_a_gnt), .B_GNT(fp_b_gnt), .A_DONE(fp_a_done), .B_DONE(fp_b_done),
      .A_RDATA(fp_a_rdata), .B_RDATA(fp_b_rdata), .A_ERR(fp_a_err), .B_ERR(fp_b_err),
      .MEM_ADDR2(fp_addr), .MEM_DIN2(fp_din), .MEM_SIZE(fp_size), .MEM_SIGN(fp_sign),
      .MEM_WRITE2(fp_write), .MEM_READ2(fp_read), .MEM_DOUT2(32'd0), .MEM_ERR(1'b0),
      .BUSY(fp_busy)
   );

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Memory with synchronous word read and slicing on the live address.
   logic [31:0] mem_w [1024] = '{default: '0};
   logic [31:0] rd_word = '0;

   function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] dn,
                                              input logic [1:0] lo, input logic [1:0] sz);
      logic [31:0] m, d;
      case (sz)
         2'd0:    begin m = 32'h0000_00FF << {lo, 3'b000};     d = {4{dn[7:0]}};  end
         2'd1:    begin m = 32'h0000_FFFF << {lo[1], 4'b0000}; d = {2{dn[15:0]}}; end
         default: begin m = '1;                                 d = dn;            end
      endcase
      return (old & ~m) | (d & m);
   endfunction

   assign mem_err = (mem_size == 2'd1 && mem_addr[0]) || (mem_size >= 2'd2 && mem_addr[1:0] != 2'd0);

   always @(posedge clk) begin
      if (mem_write && !mem_err)
         mem_w[mem_addr[11:2]] <= lane_merge(mem_w[mem_addr[11:2]], mem_din, mem_addr[1:0], mem_size);
      if (mem_read) rd_word <= mem_w[mem_addr[11:2]];
   end

   always_comb begin
      mem_sh = rd_word >> {mem_addr[1:0], 3'b000};
      case (mem_size)
         2'd0:    mem_dout = mem_sign ? {24'd0, mem_sh[7:0]}  : {{24{mem_sh[7]}}, mem_sh[7:0]};
         2'd1:    mem_dout = mem_sign ? {16'd0, mem_sh[15:0]} : {{16{mem_sh[15]}}, mem_sh[15:0]};
         default: mem_dout = rd_word;
      endcase
      if (mem_err) mem_dout = '0;
   end

   // Reference: flat byte memory, little-endian, misaligned accesses flagged and not performed.
   logic [7:0] ref_b [4096] = '{default: '0};

   function automatic logic mis(input logic [31:0] ad, input logic [1:0] sz);
      return (sz == 2'd1 && ad[0]) || (sz >= 2'd2 && ad[1:0] != 2'd0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] ad, input logic [1:0] sz, input logic sg);
      int unsigned b;
      logic [15:0] h;
      b = int'(ad[11:0]);
      if (mis(ad, sz)) return '0;
      if (sz == 2'd0) return sg ? {24'd0, ref_b[b]} : {{24{ref_b[b][7]}}, ref_b[b]};
      h = {ref_b[b+1], ref_b[b]};
      if (sz == 2'd1) return sg ? {16'd0, h} : {{16{h[15]}}, h};
      return {ref_b[b+3], ref_b[b+2], h};
   endfunction

   function automatic void ref_store(input logic [31:0] ad, input logic [31:0] dn, input logic [1:0] sz);
      int unsigned b;
      b = int'(ad[11:0]);
      if (mis(ad, sz)) return;
      ref_b[b] = dn[7:0];
      if (sz >= 2'd1) ref_b[b+1] = dn[15:8];
      if (sz >= 2'd2) begin ref_b[b+2] = dn[23:16]; ref_b[b+3] = dn[31:24]; end
   endfunction

   // Transaction-level monitor for the round-robin instance.
   logic        m_idle_prev = 1'b1;
   logic        m_last = 1'b1;
   int unsigned m_busy = 0;
   int unsigned m_dcnt [2] = '{0, 0};
   logic [31:0] m_hold [2] = '{32'd0, 32'd0};
   logic [31:0] m_exp_rd [2] = '{32'd0, 32'd0};
   logic        m_exp_err [2] = '{1'b0, 1'b0};
   logic        m_is_st [2] = '{1'b0, 1'b0};
   logic [31:0] m_st_addr [2] = '{32'd0, 32'd0};
   logic [31:0] m_st_din [2] = '{32'd0, 32'd0};
   logic [1:0]  m_st_size [2] = '{2'd0, 2'd0};
   logic [31:0] m_resp_addr = '0;
   logic [1:0]  m_resp_size = '0;
   logic        m_resp_sign = 1'b0;

   always @(negedge clk) begin
      logic [1:0]  g, r, d, e, eg;
      logic [31:0] rd [2];
      logic        exp_d, we, sg;
      logic [31:0] ad, dn;
      logic [1:0]  sz;
      int          s;
      if (!rst_n) begin
         m_idle_prev = 1'b1;
         m_busy      = 0;
         m_last      = 1'b1;
         for (int i = 0; i < 2; i++) begin m_dcnt[i] = 0; m_hold[i] = '0; end
      end else begin
         g = {b_gnt, a_gnt};
         r = {b_req, a_req};
         d = {b_done, a_done};
         e = {b_err, a_err};
         rd[0] = a_rdata;
         rd[1] = b_rdata;
         for (int i = 0; i < 2; i++) begin
            exp_d = (m_dcnt[i] == 1);
            check(i == 0 ? "a_done" : "b_done", 160'(d[i]), 160'(exp_d));
            if (exp_d) begin
               check(i == 0 ? "a_err" : "b_err", 160'(e[i]), 160'(m_exp_err[i]));
               if (m_is_st[i]) ref_store(m_st_addr[i], m_st_din[i], m_st_size[i]);
               else            m_hold[i] = m_exp_rd[i];
            end
            if (m_dcnt[i] != 0) m_dcnt[i]--;
            check(i == 0 ? "a_rdata" : "b_rdata", 160'(rd[i]), 160'(m_hold[i]));
         end
         if (m_busy == 2)
            check("resp_hold", 160'({mem_write, mem_read, mem_addr, mem_size, mem_sign}),
                  160'({2'b00, m_resp_addr, m_resp_size, m_resp_sign}));
         if (m_busy != 0) m_busy--;
         if (!m_idle_prev || r == 2'b00) eg = 2'b00;
         else if (r == 2'b11)            eg = m_last ? 2'b01 : 2'b10;
         else                            eg = r;
         check("grant", 160'(g), 160'(eg));
         if (g == 2'b01 || g == 2'b10) begin
            s  = g[1] ? 1 : 0;
            we = s ? b_we : a_we;
            ad = s ? b_addr : a_addr;
            dn = s ? b_din : a_din;
            sz = s ? b_size : a_size;
            sg = s ? b_sign : a_sign;
            check("mem_bus", 160'({mem_write, mem_read, mem_addr, mem_din, mem_size, mem_sign}),
                  160'({we, ~we, ad, dn, sz, sg}));
            m_last       = g[1];
            m_busy       = we ? 1 : 2;
            m_dcnt[s]    = we ? 1 : 2;
            m_is_st[s]   = we;
            m_exp_err[s] = mis(ad, sz);
            m_exp_rd[s]  = ref_load(ad, sz, sg);
            m_st_addr[s] = ad;
            m_st_din[s]  = dn;
            m_st_size[s] = sz;
            m_resp_addr  = ad;
            m_resp_size  = sz;
            m_resp_sign  = sg;
         end
         m_idle_prev = (m_busy == 0);
      end
   end

   task automatic drive(input int side, input logic rq, input logic we, input logic [31:0] ad,
                        input logic [31:0] dn, input logic [1:0] sz, input logic sg);
      if (side == 0) begin a_req = rq; a_we = we; a_addr = ad; a_din = dn; a_size = sz; a_sign = sg; end
      else           begin b_req = rq; b_we = we; b_addr = ad; b_din = dn; b_size = sz; b_sign = sg; end
   endtask

   // Called just after a falling edge; returns just after the falling edge that shows DONE.
   task automatic do_txn(input int side, input logic we, input logic [31:0] ad, input logic [31:0] dn,
                         input logic [1:0] sz, input logic sg, output logic [31:0] rd, output logic er);
      int unsigned n;
      drive(side, 1'b1, we, ad, dn, sz, sg);
      n = 0;
      do begin @(negedge clk); n++; end while (!(side == 0 ? a_gnt : b_gnt) && n < 20);
      check("gnt_latency", 160'(n), 160'(1));
      #1 drive(side, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (!(side == 0 ? a_done : b_done) && n < 20);
      check("done_latency", 160'(n), we ? 160'(1) : 160'(2));
      rd = side == 0 ? a_rdata : b_rdata;
      er = side == 0 ? a_err : b_err;
      #1;
   endtask

   logic        r_pend [2] = '{1'b0, 1'b0};
   int unsigned r_age [2] = '{0, 0};

   initial begin
      logic [31:0] rd, prev, ad;
      logic        er;
      logic [1:0]  gv, sz;
      logic [3:0]  gs;
      int unsigned ng, fp_a, fp_b, n;

      repeat (3) @(negedge clk);
      check("rst_ctl", 160'({a_gnt, b_gnt, a_done, b_done, a_err, b_err, busy, mem_write, mem_read, mem_sign, mem_size}), '0);
      check("rst_data", 160'({a_rdata, b_rdata, mem_addr, mem_din}), '0);
      #1 rst_n = 1'b1;

      do_txn(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0, rd, er);
      do_txn(0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, rd, er);
      check("a_load_word", 160'(rd), 160'(32'hDEAD_BEEF));
      check("b_quiet", 160'({b_gnt, b_done, b_err, b_rdata}), '0);

      do_txn(1, 1'b1, 32'h200, 32'h1122_3344, 2'd2, 1'b0, rd, er);
      do_txn(1, 1'b0, 32'h203, 32'h0, 2'd0, 1'b0, rd, er);
      check("b_load_byte", 160'(rd), 160'(32'h0000_0011));
      check("a_rdata_kept", 160'(a_rdata), 160'(32'hDEAD_BEEF));

      do_txn(0, 1'b0, 32'h102, 32'h0, 2'd2, 1'b0, rd, er);
      check("a_err_misaligned", 160'(er), 160'(1));

      // Both requesting continuously from reset.
      rst_n = 1'b0;
      drive(0, 1'b1, 1'b0, 32'h40, '0, 2'd2, 1'b0);
      drive(1, 1'b1, 1'b0, 32'h44, '0, 2'd2, 1'b0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      gs = '0; ng = 0; fp_a = 0; fp_b = 0;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         if ((a_gnt || b_gnt) && ng < 4) begin gs[ng] = b_gnt; ng++; end
         if (fp_a_gnt) fp_a++;
         if (fp_b_gnt) fp_b++;
      end
      check("rr_order", 160'(gs), 160'(4'b1010));
      check("fp_b_never", 160'(fp_b), 160'(0));
      check("fp_a_wins", 160'(fp_a >= 4), 160'(1));
      #1 drive(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      drive(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      repeat (4) @(negedge clk);
      #1;

      // Reset during the ACCESS cycle of a B store.
      prev = mem_w[192];
      drive(1, 1'b1, 1'b1, 32'h300, 32'hCAFE_F00D, 2'd2, 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (!b_gnt && n < 20);
      check("rst_test_access", 160'({b_gnt, mem_write}), 160'(2'b11));
      #1 rst_n = 1'b0;
      #1 check("rst_write_drop", 160'({mem_write, busy, b_gnt}), '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      @(negedge clk);
      check("rst_mem_kept", 160'(mem_w[192]), 160'(prev));
      check("rst2_ctl", 160'({a_gnt, b_gnt, a_done, b_done, a_err, b_err, busy, mem_write, mem_read, mem_sign, mem_size}), '0);
      check("rst2_data", 160'({a_rdata, b_rdata, mem_addr, mem_din}), '0);
      #1 rst_n = 1'b1;
      repeat (3) begin @(negedge clk); check("rst_no_done", 160'(b_done), '0); end
      #1;

      // Random two-requester traffic.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         gv = {b_gnt, a_gnt};
         #1;
         for (int s = 0; s < 2; s++) begin
            if (r_pend[s] && gv[s]) r_pend[s] = 1'b0;
            if (r_pend[s]) begin
               r_age[s]++;
               if (r_age[s] > 12) begin
                  check("gnt_timeout", 160'(r_age[s]), 160'(0));
                  r_pend[s] = 1'b0;
                  drive(s, 1'b0, 1'b0, '0, '0, '0, 1'b0);
               end
            end else if ($urandom_range(0, 2) != 0) begin
               ad = 32'($urandom_range(0, 63));
               if ($urandom_range(0, 7) == 0) ad = ad | 32'h1100_0000;
               sz = 2'($urandom_range(0, 2));
               if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
               drive(s, 1'b1, 1'($urandom_range(0, 1)), ad, $urandom, sz, 1'($urandom_range(0, 1)));
               r_pend[s] = 1'b1;
               r_age[s]  = 0;
            end else begin
               drive(s, 1'b0, 1'b0, '0, '0, '0, 1'b0);
            end
         end
      end
      drive(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      drive(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      repeat (6) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
